vga_multiball: RTL



---
 rtl/vga_multiball.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vga_multiball.sv
// VGA timing generator with NBALLS bouncing square balls.
// Sync and RGB are registered together on the pixel enable so they stay aligned for any divider.
module vga_multiball #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int NBALLS     = 2,
    parameter int BALL_SIZE  = 16,
    parameter int STEP       = 1,
    parameter int COLOR_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  frame_start
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [10:0] H_END    = 11'(HT - 1);
    localparam logic [10:0] V_END    = 11'(VT - 1);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_STOP  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_STOP  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] SIZE     = 11'(BALL_SIZE);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] X_LIM    = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_LIM    = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] X_TURN   = 11'(H_ACTIVE - BALL_SIZE - STEP);
    localparam logic [10:0] Y_TURN   = 11'(V_ACTIVE - BALL_SIZE - STEP);
    localparam logic        SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic [COLOR_BITS-1:0] CMAX = {COLOR_BITS{1'b1}};
    localparam logic [COLOR_BITS-1:0] CZERO = {COLOR_BITS{1'b0}};

    logic [2:0]  div_r;
    logic        pix_en_s;
    logic [10:0] hcnt_r;
    logic [10:0] vcnt_r;
    logic [10:0] bx_r [NBALLS];
    logic [10:0] by_r [NBALLS];
    logic [NBALLS-1:0] xneg_r;
    logic [NBALLS-1:0] yneg_r;
    logic        update_s;
    logic        hs_s;
    logic        vs_s;
    logic [3*COLOR_BITS-1:0] rgb_s;

    // Returns {red, green, blue} for ball idx.
    function automatic logic [3*COLOR_BITS-1:0] ball_color(input int idx);
        logic [3*COLOR_BITS-1:0] c;
        case (idx)
            0:       c = {CMAX, CZERO, CZERO};
            1:       c = {CZERO, CMAX, CZERO};
            2:       c = {CZERO, CZERO, CMAX};
            3:       c = {CMAX, CMAX, CMAX};
            default: c = {CZERO, CZERO, CZERO};
        endcase
        return c;
    endfunction

    // One axis step: returns {moving_negative, new_position}, clamping at 0 and lim.
    function automatic logic [11:0] bounce(input logic [10:0] pos, input logic neg,
                                           input logic [10:0] lim, input logic [10:0] turn);
        logic [11:0] r;
        if (!neg) begin
            if (pos >= turn) r = {1'b1, lim};
            else             r = {1'b0, pos + STEP_W};
        end else begin
            if (pos <= STEP_W) r = {1'b0, 11'd0};
            else               r = {1'b1, pos - STEP_W};
        end
        return r;
    endfunction

    assign pix_en_s = (div_r == DIV_LAST);
    assign update_s = pix_en_s && run && (hcnt_r == 11'd0) && (vcnt_r == V_VIS);

    // Pixel clock divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         div_r <= 3'd0;
        else if (pix_en_s) div_r <= 3'd0;
        else               div_r <= div_r + 3'd1;
    end

    // Raster counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_r <= 11'd0;
            vcnt_r <= 11'd0;
        end else if (pix_en_s) begin
            if (hcnt_r == H_END) begin
                hcnt_r <= 11'd0;
                if (vcnt_r == V_END) vcnt_r <= 11'd0;
                else                 vcnt_r <= vcnt_r + 11'd1;
            end else begin
                hcnt_r <= hcnt_r + 11'd1;
            end
        end
    end

    // Sync decode and pixel colour for the current counter position.
    always_comb begin
        hs_s  = ~SYNC_ON;
        vs_s  = ~SYNC_ON;
        rgb_s = {3*COLOR_BITS{1'b0}};
        if (hcnt_r >= HS_START && hcnt_r < HS_STOP) hs_s = SYNC_ON;
        else                                        hs_s = ~SYNC_ON;
        if (vcnt_r >= VS_START && vcnt_r < VS_STOP) vs_s = SYNC_ON;
        else                                        vs_s = ~SYNC_ON;
        if (hcnt_r < H_VIS && vcnt_r < V_VIS) begin
            // Walk from the highest index down so the lowest index ends up on top.
            for (int i = NBALLS - 1; i >= 0; i--) begin
                if (hcnt_r >= bx_r[i] && hcnt_r < bx_r[i] + SIZE &&
                    vcnt_r >= by_r[i] && vcnt_r < by_r[i] + SIZE)
                    rgb_s = ball_color(i);
                else
                    rgb_s = rgb_s;
            end
        end else begin
            rgb_s = {3*COLOR_BITS{1'b0}};
        end
    end

    // Registered video outputs and frame marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_hs      <= ~SYNC_ON;
            vga_vs      <= ~SYNC_ON;
            red         <= CZERO;
            green       <= CZERO;
            blue        <= CZERO;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en_s && (hcnt_r == H_END) && (vcnt_r == V_END);
            if (pix_en_s) begin
                vga_hs              <= hs_s;
                vga_vs              <= vs_s;
                {red, green, blue}  <= rgb_s;
            end
        end
    end

    // Ball motion, applied once per frame on the first blanking line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBALLS; i++) begin
                bx_r[i]   <= 11'(32 + 64 * i);
                by_r[i]   <= 11'(32 + 48 * i);
                xneg_r[i] <= ((i % 2) != 0);
                yneg_r[i] <= 1'b0;
            end
        end else if (update_s) begin
            for (int i = 0; i < NBALLS; i++) begin
                {xneg_r[i], bx_r[i]} <= bounce(bx_r[i], xneg_r[i], X_LIM, X_TURN);
                {yneg_r[i], by_r[i]} <= bounce(by_r[i], yneg_r[i], Y_LIM, Y_TURN);
            end
        end
    end

endmodule
